rtc_bus_sequencer: RTL and testbench

- Parametrised successor of the date-programming block.
- Runs a burst of NUM_REGS register transactions to the external RTC over its multiplexed address/data bus (AD, RD, WR, CS strobes). Each transaction is either a write or a read, selected by Modo.
- Sits between the control FSM and the RTC pins; it is reused for date, time and timer programming and for readback.

---
 rtl/rtc_seq_pkg.sv | 27 ++
 rtl/rtc_phase_timer.sv | 32 +++
 rtl/rtc_bus_sequencer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_seq_pkg.sv
// Shared definitions for the RTC bus sequencer: FSM state encoding,
// default RTC address map, strobe idle level and the BCD nibble helper.
package rtc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_HOLD = 3'd2,
        ST_DATA      = 3'd3,
        ST_DATA_HOLD = 3'd4,
        ST_DONE      = 3'd5
    } seq_state_e;

    // Default RTC register map
    localparam logic [7:0] RTC_ADDR_DATE = 8'h24;
    localparam logic [7:0] RTC_ADDR_TIME = 8'h21;
    localparam logic [7:0] RTC_ADDR_CMD  = 8'hF0;

    // Level of every active-low strobe when the bus is quiet
    localparam logic STROBE_IDLE = 1'b1;

    // A BCD digit is valid only in the range 0..9
    function automatic logic bcd_nibble_ok(input logic [3:0] nib);
        return (nib <= 4'd9);
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that times one bus phase. Loading N-1 makes the
// terminal-count pulse appear on the N-th cycle after the load edge.
module rtc_phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          tc
);

    logic [CW-1:0] cnt_r;

    // Count down after a load; tc is high on the cycle the count sits at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
            tc    <= 1'b0;
        end else if (load) begin
            cnt_r <= load_val;
            tc    <= (load_val == {CW{1'b0}});
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
            tc    <= (cnt_r == CW'(1));
        end else begin
            cnt_r <= cnt_r;
            tc    <= 1'b0;
        end
    end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Runs a burst of NUM_REGS write or read transactions on the RTC's
// multiplexed address/data bus. All pin outputs are registered and derived
// from the next FSM state so they change exactly on phase boundaries.
// Optional feature macro: RTC_SEQ_BCD_CHECK_EN (BCD validation + sticky Error).
module rtc_bus_sequencer
    import rtc_seq_pkg::*;
#(
    parameter int                NUM_REGS  = 3,
    parameter int                DATA_W    = 8,
    parameter int                PHASE_CYC = 4,
    parameter logic [DATA_W-1:0] ADDR_BASE = RTC_ADDR_DATE
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Inicie,
    input  logic                       Modo,
    input  logic [NUM_REGS*DATA_W-1:0] Dato_in,
    input  logic [DATA_W-1:0]          Bus_in,
    output logic [DATA_W-1:0]          Direccion1,
    output logic                       Bus_oe,
    output logic                       AD,
    output logic                       RD,
    output logic                       WR,
    output logic                       CS,
    output logic [NUM_REGS*DATA_W-1:0] Dato_out,
    output logic                       Ocupado,
    output logic                       Listo,
    output logic                       Error
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CW = $clog2(PHASE_CYC);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);
    localparam logic [CW-1:0] PH_LOAD  = CW'(PHASE_CYC - 1);

    seq_state_e                 state_r, state_nxt_s;
    logic [IW-1:0]              idx_r, idx_nxt_s;
    logic                       modo_r, modo_nxt_s;
    logic [NUM_REGS*DATA_W-1:0] wdata_r, wdata_nxt_s;
    logic                       inicie_d_r;
    logic                       start_s;
    logic                       tc_s;
    logic                       load_s;
    logic [CW-1:0]              load_val_s;
    logic                       capture_s;
    logic                       bcd_bad_s;
    logic [DATA_W-1:0]          addr_s;
    logic [DATA_W-1:0]          dir_s;
    logic                       oe_s, ad_s, rd_s, wr_s, cs_s;

    assign start_s = Inicie && !inicie_d_r && (state_r == ST_IDLE);

    rtc_phase_timer #(
        .CW(CW)
    ) u_timer (
        .clk      (Clock),
        .rst_n    (Reset),
        .load     (load_s),
        .load_val (load_val_s),
        .tc       (tc_s)
    );

`ifdef RTC_SEQ_BCD_CHECK_EN
    logic rd_bad_s;

    // Flag a write burst whose data contains any non-BCD digit
    always_comb begin
        bcd_bad_s = 1'b0;
        for (int i = 0; i < (NUM_REGS * DATA_W) / 4; i++) begin
            if (!bcd_nibble_ok(Dato_in[4*i +: 4])) begin
                bcd_bad_s = !Modo;
            end else begin
                bcd_bad_s = bcd_bad_s;
            end
        end
    end

    // Flag a read byte containing any non-BCD digit
    always_comb begin
        rd_bad_s = 1'b0;
        for (int i = 0; i < DATA_W / 4; i++) begin
            if (!bcd_nibble_ok(Bus_in[4*i +: 4])) begin
                rd_bad_s = 1'b1;
            end else begin
                rd_bad_s = rd_bad_s;
            end
        end
    end

    // Sticky fault flag, cleared only by reset
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Error <= 1'b0;
        end else if ((start_s && bcd_bad_s) || (capture_s && rd_bad_s)) begin
            Error <= 1'b1;
        end else begin
            Error <= Error;
        end
    end
`else
    assign bcd_bad_s = 1'b0;
    assign Error     = 1'b0;
`endif

    // State, index and latched burst parameters
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IW{1'b0}};
            modo_r     <= 1'b0;
            wdata_r    <= {(NUM_REGS*DATA_W){1'b0}};
            inicie_d_r <= Inicie;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            modo_r     <= modo_nxt_s;
            wdata_r    <= wdata_nxt_s;
            inicie_d_r <= Inicie;
        end
    end

    // Next-state logic; a rejected write burst skips straight to a one-cycle
    // quiet DATA_HOLD on the last index so it ends without any bus cycle
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        modo_nxt_s  = modo_r;
        wdata_nxt_s = wdata_r;
        load_s      = 1'b0;
        load_val_s  = PH_LOAD;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    modo_nxt_s  = Modo;
                    wdata_nxt_s = Dato_in;
                    load_s      = 1'b1;
                    if (bcd_bad_s) begin
                        state_nxt_s = ST_DATA_HOLD;
                        idx_nxt_s   = LAST_IDX;
                        load_val_s  = {CW{1'b0}};
                    end else begin
                        state_nxt_s = ST_ADDR;
                        idx_nxt_s   = {IW{1'b0}};
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (tc_s) begin
                    state_nxt_s = ST_ADDR_HOLD;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_ADDR_HOLD: begin
                if (tc_s) begin
                    state_nxt_s = ST_DATA;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_ADDR_HOLD;
                end
            end
            ST_DATA: begin
                if (tc_s) begin
                    state_nxt_s = ST_DATA_HOLD;
                    load_s      = 1'b1;
                    capture_s   = modo_r;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_DATA_HOLD: begin
                if (tc_s) begin
                    if (idx_r < LAST_IDX) begin
                        state_nxt_s = ST_ADDR;
                        idx_nxt_s   = idx_r + IW'(1);
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_DATA_HOLD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign addr_s = ADDR_BASE + DATA_W'(idx_nxt_s);

    // Pin levels for the state being entered; write drives WR, read drives RD
    always_comb begin
        ad_s  = STROBE_IDLE;
        rd_s  = STROBE_IDLE;
        wr_s  = STROBE_IDLE;
        cs_s  = STROBE_IDLE;
        oe_s  = 1'b0;
        dir_s = {DATA_W{1'b0}};
        case (state_nxt_s)
            ST_ADDR: begin
                cs_s  = 1'b0;
                ad_s  = 1'b0;
                oe_s  = 1'b1;
                dir_s = addr_s;
                if (modo_nxt_s) begin
                    rd_s = 1'b0;
                end else begin
                    wr_s = 1'b0;
                end
            end
            ST_ADDR_HOLD: begin
                cs_s  = 1'b0;
                ad_s  = 1'b0;
                oe_s  = 1'b1;
                dir_s = addr_s;
            end
            ST_DATA: begin
                cs_s = 1'b0;
                ad_s = 1'b1;
                if (modo_nxt_s) begin
                    rd_s = 1'b0;
                end else begin
                    wr_s  = 1'b0;
                    oe_s  = 1'b1;
                    dir_s = wdata_nxt_s[idx_nxt_s*DATA_W +: DATA_W];
                end
            end
            ST_DATA_HOLD: begin
                ad_s = 1'b1;
            end
            default: begin
                ad_s = STROBE_IDLE;
            end
        endcase
    end

    // Registered bus pins and handshake outputs
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            AD         <= STROBE_IDLE;
            RD         <= STROBE_IDLE;
            WR         <= STROBE_IDLE;
            CS         <= STROBE_IDLE;
            Bus_oe     <= 1'b0;
            Direccion1 <= {DATA_W{1'b0}};
            Ocupado    <= 1'b0;
            Listo      <= 1'b0;
        end else begin
            AD         <= ad_s;
            RD         <= rd_s;
            WR         <= wr_s;
            CS         <= cs_s;
            Bus_oe     <= oe_s;
            Direccion1 <= dir_s;
            Ocupado    <= (state_nxt_s != ST_IDLE);
            Listo      <= (state_nxt_s == ST_DONE);
        end
    end

    // Read data capture on the last DATA cycle; write bursts leave it alone
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Dato_out <= {(NUM_REGS*DATA_W){1'b0}};
        end else if (capture_s) begin
            Dato_out[idx_r*DATA_W +: DATA_W] <= Bus_in;
        end else begin
            Dato_out <= Dato_out;
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer. A cycle-position model derives
// every expected pin level from the burst start time; directed tests add
// hand-computed literal checks. Define RTC_SEQ_BCD_CHECK_EN to cover the BCD check.
module tb_rtc_bus_sequencer;

    localparam int N     = 3;
    localparam int P     = 4;
    localparam int TOTAL = N * 4 * P;

    logic        Clock = 1'b0;
    logic        Reset, Inicie, Modo;
    logic [23:0] Dato_in;
    logic [7:0]  Bus_in;
    logic [7:0]  Direccion1;
    logic        Bus_oe, AD, RD, WR, CS, Ocupado, Listo, Error;
    logic [23:0] Dato_out;

    logic        Inicie2;
    logic [7:0]  Dato_in2, Bus_in2, Direccion1_2, Dato_out2;
    logic        Bus_oe2, AD2, RD2, WR2, CS2, Ocupado2, Listo2, Error2;

    rtc_bus_sequencer #(.NUM_REGS(N), .DATA_W(8), .PHASE_CYC(P), .ADDR_BASE(8'h24)) dut (
        .Clock(Clock), .Reset(Reset), .Inicie(Inicie), .Modo(Modo),
        .Dato_in(Dato_in), .Bus_in(Bus_in), .Direccion1(Direccion1), .Bus_oe(Bus_oe),
        .AD(AD), .RD(RD), .WR(WR), .CS(CS), .Dato_out(Dato_out),
        .Ocupado(Ocupado), .Listo(Listo), .Error(Error)
    );

    rtc_bus_sequencer #(.NUM_REGS(1), .DATA_W(8), .PHASE_CYC(2), .ADDR_BASE(8'hFF)) dut2 (
        .Clock(Clock), .Reset(Reset), .Inicie(Inicie2), .Modo(1'b0),
        .Dato_in(Dato_in2), .Bus_in(Bus_in2), .Direccion1(Direccion1_2), .Bus_oe(Bus_oe2),
        .AD(AD2), .RD(RD2), .WR(WR2), .CS(CS2), .Dato_out(Dato_out2),
        .Ocupado(Ocupado2), .Listo(Listo2), .Error(Error2)
    );

    always #5 Clock = ~Clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit bcd_ok(input logic [7:0] b);
        return ((b % 16) <= 9) && ((b / 16) <= 9);
    endfunction

    // ---------------- behavioural model ----------------
    bit          busy_m = 1'b0, short_m = 1'b0, mode_m = 1'b0, prev_m = 1'b0, err_m = 1'b0;
    int          k_m = 0;
    logic [23:0] data_m = 24'h0, dout_m = 24'h0;
    logic [7:0]  rd_tab [3] = '{8'h31, 8'h12, 8'h99};

    // Model update plus per-cycle comparison, just after each rising edge
    always @(posedge Clock) begin
        int r, ph, off, last;
        logic e_ad, e_rd, e_wr, e_cs, e_oe, e_busy, e_listo;
        logic [7:0] e_dir;
        #1;
        last = short_m ? 2 : TOTAL + 1;
        if (!Reset) begin
            busy_m = 1'b0; k_m = 0; dout_m = 24'h0; err_m = 1'b0;
        end else if (busy_m) begin
            r = (k_m - 1) / (4 * P); ph = ((k_m - 1) % (4 * P)) / P; off = (k_m - 1) % P;
            if (!short_m && mode_m && k_m <= TOTAL && ph == 2 && off == P - 1) begin
                dout_m[r*8 +: 8] = Bus_in;
`ifdef RTC_SEQ_BCD_CHECK_EN
                if (!bcd_ok(Bus_in)) err_m = 1'b1;
`endif
            end
            k_m++;
            if (k_m > last) busy_m = 1'b0;
        end else if (Inicie && !prev_m) begin
            busy_m = 1'b1; k_m = 1; mode_m = Modo; data_m = Dato_in; short_m = 1'b0;
`ifdef RTC_SEQ_BCD_CHECK_EN
            if (!Modo && !(bcd_ok(Dato_in[7:0]) && bcd_ok(Dato_in[15:8]) && bcd_ok(Dato_in[23:16]))) begin
                short_m = 1'b1; err_m = 1'b1;
            end
`endif
        end
        prev_m = Inicie;
        last = short_m ? 2 : TOTAL + 1;

        e_ad = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_cs = 1'b1; e_oe = 1'b0; e_dir = 8'h00;
        e_busy = busy_m; e_listo = busy_m && (k_m == last);
        if (busy_m && !short_m && k_m <= TOTAL) begin
            r = (k_m - 1) / (4 * P); ph = ((k_m - 1) % (4 * P)) / P;
            if (ph == 0 || ph == 1) begin
                e_cs = 1'b0; e_ad = 1'b0; e_oe = 1'b1; e_dir = 8'h24 + 8'(r);
                if (ph == 0) begin
                    if (mode_m) e_rd = 1'b0; else e_wr = 1'b0;
                end
            end else if (ph == 2) begin
                e_cs = 1'b0;
                if (mode_m) e_rd = 1'b0;
                else begin e_wr = 1'b0; e_oe = 1'b1; e_dir = data_m[r*8 +: 8]; end
            end
        end
        chk("AD", 32'(AD), 32'(e_ad));
        chk("RD", 32'(RD), 32'(e_rd));
        chk("WR", 32'(WR), 32'(e_wr));
        chk("CS", 32'(CS), 32'(e_cs));
        chk("Bus_oe", 32'(Bus_oe), 32'(e_oe));
        chk("Ocupado", 32'(Ocupado), 32'(e_busy));
        chk("Listo", 32'(Listo), 32'(e_listo));
        chk("Dato_out", 32'(Dato_out), 32'(dout_m));
        chk("Error", 32'(Error), 32'(err_m));
        if (e_oe || !Reset) chk("Direccion1", 32'(Direccion1), 32'(e_dir));
    end

    // Bus_in returns the read byte only on the last DATA cycle, junk otherwise
    always @(negedge Clock) begin
        int r, ph, off;
        Bus_in = 8'hEE;
        if (busy_m && mode_m && !short_m && k_m >= 1 && k_m <= TOTAL) begin
            r = (k_m - 1) / (4 * P); ph = ((k_m - 1) % (4 * P)) / P; off = (k_m - 1) % P;
            if (ph == 2 && off == P - 1) Bus_in = rd_tab[r];
        end
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] dirq[$];

    task automatic burst_measure(input int win, input bit drop, output int listo_cyc,
                                 output int ocup_cnt, output int n_listo, output int cs_low);
        logic       last_oe;
        logic [7:0] last_dir;
        listo_cyc = 0; ocup_cnt = 0; n_listo = 0; cs_low = 0;
        dirq.delete(); last_oe = 1'b0; last_dir = 8'h00;
        @(posedge Clock);
        for (int j = 1; j <= win; j++) begin
            #1;
            if (Listo) begin n_listo++; if (listo_cyc == 0) listo_cyc = j; end
            if (Ocupado) ocup_cnt++;
            if (!CS) cs_low++;
            if (Bus_oe && (!last_oe || Direccion1 != last_dir)) dirq.push_back(Direccion1);
            last_oe = Bus_oe; last_dir = Direccion1;
            @(negedge Clock);
            if (drop && j == 1) Inicie = 1'b0;
            @(posedge Clock);
        end
    endtask

    initial begin
        int lc, oc, nl, csl, l2;
        logic [7:0] exp_seq [6] = '{8'h24, 8'h05, 8'h25, 8'h04, 8'h26, 8'h16};
        Reset = 1'b0; Inicie = 1'b0; Modo = 1'b0; Dato_in = 24'h0;
        Inicie2 = 1'b0; Dato_in2 = 8'h42; Bus_in2 = 8'h00;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        // Write burst
        Dato_in = 24'h160405; Modo = 1'b0; Inicie = 1'b1;
        burst_measure(70, 1'b1, lc, oc, nl, csl);
        chk("wr_listo_cycle", 32'(lc), 32'd49);
        chk("wr_ocupado_cycles", 32'(oc), 32'd49);
        chk("wr_listo_count", 32'(nl), 32'd1);
        chk("wr_dir_count", 32'(dirq.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < dirq.size()) chk($sformatf("wr_dir_seq%0d", i), 32'(dirq[i]), 32'(exp_seq[i]));
        chk("wr_dato_out_untouched", 32'(Dato_out), 32'h000000);

        // Read burst
        @(negedge Clock); Modo = 1'b1; Inicie = 1'b1;
        burst_measure(70, 1'b1, lc, oc, nl, csl);
        chk("rd_listo_cycle", 32'(lc), 32'd49);
        chk("rd_dato_out", 32'(Dato_out), 32'h991231);

        // Inicie held high for 200 cycles
        @(negedge Clock); Modo = 1'b0; Dato_in = 24'h123456; Inicie = 1'b1;
        burst_measure(200, 1'b0, lc, oc, nl, csl);
        chk("hold_listo_count", 32'(nl), 32'd1);
        chk("hold_ocupado_cycles", 32'(oc), 32'd49);
        @(negedge Clock); Inicie = 1'b0;
        @(negedge Clock);

        // Second rising edge in mid-burst is ignored
        Inicie = 1'b1;
        fork
            burst_measure(80, 1'b0, lc, oc, nl, csl);
            begin
                repeat (10) @(negedge Clock); Inicie = 1'b0;
                @(negedge Clock); Inicie = 1'b1;
                @(negedge Clock); Inicie = 1'b0;
            end
        join
        chk("mid_listo_cycle", 32'(lc), 32'd49);
        chk("mid_listo_count", 32'(nl), 32'd1);
        chk("mid_dato_out_kept", 32'(Dato_out), 32'h991231);

        // Reset in the middle of a write burst
        @(negedge Clock); Dato_in = 24'h160405; Inicie = 1'b1;
        @(negedge Clock); Inicie = 1'b0;
        repeat (18) @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock); #1;
        chk("rst_strobes", 32'({AD, RD, WR, CS}), 32'hF);
        chk("rst_bus_oe", 32'(Bus_oe), 32'd0);
        chk("rst_ocupado", 32'(Ocupado), 32'd0);
        chk("rst_listo", 32'(Listo), 32'd0);
        @(negedge Clock); Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Inicie = 1'b1;
        burst_measure(70, 1'b1, lc, oc, nl, csl);
        chk("post_rst_listo_cycle", 32'(lc), 32'd49);
        chk("post_rst_ocupado_cycles", 32'(oc), 32'd49);

        // Single register, two-cycle phases, address wraps at FF
        @(negedge Clock); Inicie2 = 1'b1;
        l2 = 0;
        @(posedge Clock);
        for (int j = 1; j <= 20; j++) begin
            #1;
            if (j == 1) begin
                chk("d2_addr", 32'(Direccion1_2), 32'hFF);
                chk("d2_wr_low", 32'(WR2), 32'd0);
                chk("d2_cs_low", 32'(CS2), 32'd0);
            end
            if (j == 5) chk("d2_data", 32'(Direccion1_2), 32'h42);
            if (Listo2 && l2 == 0) l2 = j;
            @(negedge Clock);
            if (j == 1) Inicie2 = 1'b0;
            @(posedge Clock);
        end
        chk("d2_listo_cycle", 32'(l2), 32'd9);

`ifdef RTC_SEQ_BCD_CHECK_EN
        // Non-BCD write data: no bus cycles, sticky Error, early Listo
        @(negedge Clock); Modo = 1'b0; Dato_in = 24'h1A0405; Inicie = 1'b1;
        burst_measure(20, 1'b1, lc, oc, nl, csl);
        chk("bcd_listo_cycle", 32'(lc), 32'd2);
        chk("bcd_cs_low_cycles", 32'(csl), 32'd0);
        chk("bcd_error", 32'(Error), 32'd1);
        @(negedge Clock); Reset = 1'b0;
        @(negedge Clock); Reset = 1'b1;
        @(negedge Clock);
        chk("bcd_error_cleared", 32'(Error), 32'd0);
`endif

        repeat (3) @(negedge Clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
